// File: rtl/risc_pkg.sv
// Shared constants for the RISC instruction sequencer: opcodes, ALU selects,
// sequencer states and default datapath widths.
package risc_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RADDR_W = 4;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'hF;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_CMP = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/risc_decode.sv
// Opcode decoder: ALU select plus the control class of each instruction.
import risc_pkg::*;

module risc_decode (
  input  logic [3:0] opcode,
  output logic [2:0] alu_c,
  output logic       writes_back,
  output logic       is_cmp,
  output logic       is_ldi,
  output logic       is_illegal
);

  always_comb begin
    alu_c       = ALU_AND;
    writes_back = 1'b0;
    is_cmp      = 1'b0;
    is_ldi      = 1'b0;
    is_illegal  = 1'b0;
    case (opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB: begin
        alu_c       = opcode[2:0];
        writes_back = 1'b1;
      end
      OP_CMP: begin
        alu_c  = ALU_CMP;
        is_cmp = 1'b1;
      end
      OP_LDI: begin
        is_ldi      = 1'b1;
        writes_back = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/risc_sequencer.sv
// Multi-cycle sequencer: accepts one instruction, steps READ/EXEC/WB against the
// external register file and ALU, and holds the architectural flags.
//   state | meaning
//   IDLE  | ready for an instruction; illegal opcodes are rejected here
//   READ  | operand addresses presented, register file latches operands
//   EXEC  | ALU select driven, result and flags captured
//   WB    | result written to the destination register
import risc_pkg::*;

module risc_sequencer #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [15:0]        instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [RADDR_W-1:0] a_addr,
  output logic [RADDR_W-1:0] b_addr,
  output logic [RADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0]  w_word,
  output logic               load,
  input  logic [DATA_W-1:0]  a_read,
  output logic [2:0]         alu_c,
  output logic               alu_cin,
  input  logic [DATA_W-1:0]  alu_z,
  input  logic               alu_cout,
  input  logic               alu_lt,
  input  logic               alu_eq,
  input  logic               alu_gt,
  output logic               carry_q,
  output logic               lt_q,
  output logic               eq_q,
  output logic               gt_q,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  state_t              state, state_nxt;
  logic [11:0]         ir;
  logic [2:0]          ir_alu_c;
  logic                ir_wb, ir_cmp, ir_ldi;
  logic [DATA_W-1:0]   result;
  logic                done_q, illegal_q;

  logic [2:0]          dec_alu_c;
  logic                dec_wb, dec_cmp, dec_ldi, dec_illegal;

  risc_decode u_decode (
    .opcode      (instr_in[15:12]),
    .alu_c       (dec_alu_c),
    .writes_back (dec_wb),
    .is_cmp      (dec_cmp),
    .is_ldi      (dec_ldi),
    .is_illegal  (dec_illegal)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs depend only on state and registered instruction fields.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    a_addr      = '0;
    b_addr      = '0;
    c_addr      = '0;
    w_word      = '0;
    load        = 1'b0;
    alu_c       = '0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid && !dec_illegal)
          state_nxt = dec_ldi ? WB : READ;
      end
      READ: begin
        a_addr    = ir[11:8];
        b_addr    = ir[7:4];
        state_nxt = EXEC;
      end
      EXEC: begin
        a_addr    = ir[11:8];
        b_addr    = ir[7:4];
        alu_c     = ir_alu_c;
        state_nxt = ir_wb ? WB : IDLE;
      end
      WB: begin
        load      = 1'b1;
        c_addr    = ir_ldi ? ir[11:8] : ir[3:0];
        w_word    = result;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ir        <= '0;
      ir_alu_c  <= '0;
      ir_wb     <= 1'b0;
      ir_cmp    <= 1'b0;
      ir_ldi    <= 1'b0;
      result    <= '0;
      carry_q   <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          ir       <= instr_in[11:0];
          ir_alu_c <= dec_alu_c;
          ir_wb    <= dec_wb;
          ir_cmp   <= dec_cmp;
          ir_ldi   <= dec_ldi;
          if (dec_illegal) illegal_q <= 1'b1;
          if (dec_ldi)     result    <= DATA_W'(instr_in[7:0]);
        end
        EXEC: begin
          result <= alu_z;
          if (ir_alu_c == ALU_ADD) carry_q <= alu_cout;
          if (ir_cmp) begin
            lt_q   <= alu_lt;
            eq_q   <= alu_eq;
            gt_q   <= alu_gt;
            done_q <= 1'b1;
          end
        end
        WB:      done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign done    = done_q;
  assign illegal = illegal_q;
  assign alu_cin = 1'b0;

  // Operand port A must carry defined data by the time the ALU is selected.
  a_read_defined: assert property (@(posedge clock) disable iff (clear)
    (state == EXEC) |-> !$isunknown(a_read));

endmodule

// File: tb/tb_risc_sequencer.sv
// Bench for risc_sequencer: behavioural register file and ALU around the DUT,
// directed scenarios followed by random instructions against an ISA-level model.
module tb_risc_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  a_addr, b_addr, c_addr;
  logic [15:0] w_word;
  logic        load;
  logic [15:0] a_read;
  logic [2:0]  alu_c;
  logic        alu_cin;
  logic [15:0] alu_z;
  logic        alu_cout, alu_lt, alu_eq, alu_gt;
  logic        carry_q, lt_q, eq_q, gt_q;
  logic        busy, done, illegal;

  int checks = 0;
  int failures = 0;

  logic [15:0] rf [16];
  logic [15:0] a_q, b_q;
  logic [16:0] sum17;

  int ref_rf [16];
  int ref_carry, ref_lt, ref_eq, ref_gt;

  always #5 clock = ~clock;

  risc_sequencer dut (
    .clock(clock), .clear(clear), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .w_word(w_word), .load(load), .a_read(a_read), .alu_c(alu_c), .alu_cin(alu_cin),
    .alu_z(alu_z), .alu_cout(alu_cout), .alu_lt(alu_lt), .alu_eq(alu_eq), .alu_gt(alu_gt),
    .carry_q(carry_q), .lt_q(lt_q), .eq_q(eq_q), .gt_q(gt_q),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always @(posedge clock) begin
    if (load) rf[c_addr] <= w_word;
    a_q <= rf[a_addr];
    b_q <= rf[b_addr];
  end
  assign a_read = a_q;

  always_comb begin
    alu_z    = '0;
    alu_cout = 1'b0;
    sum17    = {1'b0, a_q} + {1'b0, b_q};
    case (alu_c)
      3'd0: alu_z = a_q & b_q;
      3'd1: alu_z = a_q | b_q;
      3'd2: begin alu_z = sum17[15:0]; alu_cout = sum17[16]; end
      3'd3, 3'd7: alu_z = a_q - b_q;
      default: ;
    endcase
    alu_lt = (a_q < b_q);
    alu_eq = (a_q == b_q);
    alu_gt = (a_q > b_q);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ISA-level reference: registers as integers, flags as integers.
  function automatic void model_apply(input logic [15:0] ins);
    int op, a, b, rd;
    op = int'(ins[15:12]);
    a  = ref_rf[ins[11:8]];
    b  = ref_rf[ins[7:4]];
    rd = int'(ins[3:0]);
    case (op)
      0: ref_rf[rd] = a & b;
      1: ref_rf[rd] = a | b;
      2: begin ref_rf[rd] = (a + b) % 65536; ref_carry = (a + b > 65535) ? 1 : 0; end
      3: ref_rf[rd] = (a - b + 65536) % 65536;
      7: begin
        ref_lt = (a < b) ? 1 : 0;
        ref_eq = (a == b) ? 1 : 0;
        ref_gt = (a > b) ? 1 : 0;
      end
      15: ref_rf[ins[11:8]] = int'(ins[7:0]);
      default: ;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags();
    return {ref_carry[0], ref_lt[0], ref_eq[0], ref_gt[0]};
  endfunction

  task automatic run_instr(input logic [15:0] ins);
    int op, exp_wr, exp_ill, exp_wcyc, exp_dcyc;
    int nload, load_cyc, ndone, done_cyc, nill, ill_cyc;
    logic [3:0]  exp_addr, load_addr, fl2;
    logic [15:0] load_data;
    nload = 0; load_cyc = -1; ndone = 0; done_cyc = -1; nill = 0; ill_cyc = -1;
    load_addr = '0; load_data = '0; fl2 = '0;
    op       = int'(ins[15:12]);
    exp_wr   = (op <= 3 || op == 15) ? 1 : 0;
    exp_ill  = (op <= 3 || op == 7 || op == 15) ? 0 : 1;
    exp_addr = (op == 15) ? ins[11:8] : ins[3:0];
    exp_wcyc = (op == 15) ? 0 : 2;
    exp_dcyc = (op == 15) ? 1 : ((op == 7) ? 2 : 3);
    model_apply(ins);
    @(negedge clock);
    check("ready_before_issue", instr_ready, 1);
    instr_in    = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c == 0) instr_valid = 1'b0;
      if (load) begin nload++; load_cyc = c; load_addr = c_addr; load_data = w_word; end
      if (done) begin ndone++; done_cyc = c; end
      if (illegal) begin nill++; ill_cyc = c; end
      if (c == 2) fl2 = {carry_q, lt_q, eq_q, gt_q};
      if (c == 0 && exp_ill != 0) check("illegal_keeps_ready", instr_ready, 1);
    end
    check("load_count", nload, exp_wr);
    if (exp_wr != 0) begin
      check("load_cycle", load_cyc, exp_wcyc);
      check("write_addr", load_addr, exp_addr);
      check("write_data", load_data, ref_rf[exp_addr]);
    end
    check("done_count", ndone, (exp_ill != 0) ? 0 : 1);
    if (exp_ill == 0) check("done_cycle", done_cyc, exp_dcyc);
    check("illegal_count", nill, exp_ill);
    if (exp_ill != 0) check("illegal_cycle", ill_cyc, 0);
    if (op == 7) check("cmp_flags_after_e2", fl2, ref_flags());
    check("flags", {carry_q, lt_q, eq_q, gt_q}, ref_flags());
  endtask

  task automatic run_back_to_back();
    int found;
    model_apply(16'h2123);
    model_apply(16'h3124);
    @(negedge clock);
    instr_in    = 16'h2123;
    instr_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    instr_in = 16'h3124;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("b2b_done_first", done, 1);
    check("b2b_ready_in_done", instr_ready, 1);
    @(negedge clock);
    check("b2b_second_accepted", busy, 1);
    instr_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 8 && found == 0; c++) begin
      @(negedge clock);
      if (done) found = 1;
    end
    check("b2b_second_done", found, 1);
    check("b2b_r4", rf[4], ref_rf[4]);
    check("b2b_r3", rf[3], ref_rf[3]);
  endtask

  task automatic run_clear_mid_exec();
    logic [15:0] r3_before;
    r3_before = rf[3];
    @(negedge clock);
    instr_in    = 16'h2FF3;
    instr_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    check("clr_pre_load", load, 0);
    @(negedge clock);
    check("clr_in_exec", alu_c, 3'd2);
    clear = 1'b1;
    #1;
    check("clr_load_low", load, 0);
    check("clr_ready", instr_ready, 1);
    @(negedge clock);
    clear = 1'b0;
    ref_carry = 0; ref_lt = 0; ref_eq = 0; ref_gt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("clr_outputs", {load, done, illegal, busy, instr_ready, alu_c, c_addr, w_word},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 16'd0});
    end
    check("clr_flags", {carry_q, lt_q, eq_q, gt_q}, 4'h0);
    check("clr_r3_unchanged", rf[3], r3_before);
  endtask

  initial begin
    logic [15:0] ins;
    clear       = 1'b1;
    instr_in    = '0;
    instr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf[i]     = 16'($urandom);
      ref_rf[i] = int'(rf[i]);
    end
    ref_carry = 0; ref_lt = 0; ref_eq = 0; ref_gt = 0;
    #12;
    check("rst_ready", instr_ready, 1);
    check("rst_controls", {busy, done, illegal, load, alu_cin}, 5'd0);
    check("rst_addrs", {a_addr, b_addr, c_addr, alu_c}, 15'd0);
    check("rst_wword", w_word, 16'd0);
    check("rst_flags", {carry_q, lt_q, eq_q, gt_q}, 4'h0);
    @(negedge clock);
    clear = 1'b0;

    run_instr(16'hF10F);
    run_instr(16'hF20B);
    run_instr(16'h2123);
    check("add_r3_value", rf[3], 16'h001A);
    run_instr(16'h7120);
    run_instr(16'h5123);
    run_back_to_back();
    run_clear_mid_exec();

    for (int n = 0; n < 120; n++) begin
      ins = 16'($urandom);
      if (($urandom % 4) != 0) begin
        case ($urandom_range(0, 5))
          0: ins[15:12] = 4'h0;
          1: ins[15:12] = 4'h1;
          2: ins[15:12] = 4'h2;
          3: ins[15:12] = 4'h3;
          4: ins[15:12] = 4'h7;
          default: ins[15:12] = 4'hF;
        endcase
      end
      run_instr(ins);
    end

    for (int i = 0; i < 16; i++) check("final_rf", rf[i], ref_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
